// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared widths, FSM states and coordinate helper for the k-means cluster PE
//
// Purpose: width functions derived from the PE parameters, the update FSM
// state type, and a helper that pulls one coordinate out of a packed vector.
// Ports: none (package).
package kmeans_pkg;

    // Widest packed vector the coordinate helper accepts.
    localparam int MAX_VEC_W = 1024;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    function automatic int cnt_w(input int max_n);
        return $clog2(max_n + 1);
    endfunction

    function automatic int acc_w(input int dim_w, input int max_n);
        return dim_w + cnt_w(max_n);
    endfunction

    function automatic int dep_w(input int max_depth);
        return (max_depth > 1) ? $clog2(max_depth) : 1;
    endfunction

    function automatic int c_w(input int dim, input int dim_w);
        return dim * dim_w;
    endfunction

    // Coordinate idx (w bits each, coordinate 0 in the LSBs), zero-extended.
    function automatic logic [31:0] coord_slice(input logic [MAX_VEC_W-1:0] vec,
                                                input int idx, input int w);
        return 32'(vec >> (idx * w)) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/kmeans_cluster_pe_divider.sv
// rtl/kmeans_cluster_pe_divider.sv - restoring sequential divider with start/done
//
// Purpose: unsigned dividend/divisor restoring division, one quotient bit per
// cycle. start loads the operands; DVD_W cycles later done pulses for one
// cycle with the quotient (truncated to Q_W bits) valid.
// Ports: clk, rst (sync, active-high), start, dividend[DVD_W], divisor[DVS_W],
//        quotient[Q_W], done.
module seq_divider #(
    parameter int DVD_W = 11,
    parameter int DVS_W = 3,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    localparam int IT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] quo;
    logic [DVS_W-1:0] rem;
    logic [IT_W-1:0]  iter;
    logic             busy;
    logic [DVS_W:0]   trial;

    // The remainder stays below the divisor, so the shifted trial value
    // always fits in one extra bit.
    assign trial    = {rem, quo[DVD_W-1]};
    assign quotient = quo[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo  <= dividend;
                rem  <= '0;
                iter <= IT_W'(DVD_W);
                busy <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, divisor}) begin
                    rem <= DVS_W'(trial - {1'b0, divisor});
                    quo <= {quo[DVD_W-2:0], 1'b1};
                end else begin
                    rem <= trial[DVS_W-1:0];
                    quo <= {quo[DVD_W-2:0], 1'b0};
                end
                iter <= iter - 1'b1;
                if (iter == IT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kmeans_cluster_pe.sv
// rtl/kmeans_cluster_pe.sv - k-means cluster centre PE and kd-tree sorting node
//
// Purpose: holds one DIM-dimensional cluster centre, accumulates assigned
// points, recomputes the centre as the truncated mean on update_start, and
// swaps centres with parent/child nodes while its time-to-live is non-zero.
// Ports: clk, rst (sync, active-high), depth; point stream pt_valid/pt_ready/
//        pt_data/pt_assign; forwarded point_out/point_out_valid/go_left;
//        sort_load/next_level; parent_swap/child_swap with parent_in/child_in/
//        parent_out/child_out; update_start/update_done; center/count/stable/overflow.
module kmeans_cluster_pe
    import kmeans_pkg::*;
#(
    parameter int DIM       = 3,
    parameter int DIM_W     = 8,
    parameter int MAX_N     = 1000,
    parameter int MAX_DEPTH = 16,
    parameter logic [DIM*DIM_W-1:0] INIT_CENTER = '0,
    localparam int CNT_W = cnt_w(MAX_N),
    localparam int ACC_W = acc_w(DIM_W, MAX_N),
    localparam int DEP_W = dep_w(MAX_DEPTH),
    localparam int C_W   = c_w(DIM, DIM_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEP_W-1:0] depth,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [C_W-1:0]   pt_data,
    input  logic             pt_assign,
    output logic [C_W-1:0]   point_out,
    output logic             point_out_valid,
    output logic             go_left,
    input  logic             sort_load,
    input  logic             next_level,
    input  logic             parent_swap,
    input  logic             child_swap,
    input  logic [C_W-1:0]   parent_in,
    input  logic [C_W-1:0]   child_in,
    output logic [C_W-1:0]   parent_out,
    output logic [C_W-1:0]   child_out,
    input  logic             update_start,
    output logic             update_done,
    output logic [C_W-1:0]   center,
    output logic [CNT_W-1:0] count,
    output logic             stable,
    output logic             overflow
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PH_W  = $clog2(ACC_W + 1);

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc [DIM];
    logic [IDX_W-1:0]  dim_idx, cap_idx;
    logic [PH_W-1:0]   phase;
    logic [C_W-1:0]    new_center, nc_merged;
    logic [DEP_W-1:0]  ttl;
    logic [CNT_W-1:0]  count_next;
    logic              accept, add_pt, count_full;
    logic              swap_en, do_parent, do_child;
    logic              div_start, div_done;
    logic [DIM_W-1:0]  div_quot, axis_pt, axis_ctr;
    int                axis;

    assign pt_ready   = (state == IDLE);
    assign accept     = pt_valid && pt_ready;
    assign count_full = (count == CNT_W'(MAX_N));
    assign add_pt     = accept && pt_assign && !count_full;
    // Count including this cycle's point, so a point arriving with
    // update_start takes part in the division (and defeats the empty skip).
    assign count_next = add_pt ? count + 1'b1 : count;

    assign axis     = int'(depth) % DIM;
    assign axis_pt  = DIM_W'(coord_slice(MAX_VEC_W'(pt_data), axis, DIM_W));
    assign axis_ctr = DIM_W'(coord_slice(MAX_VEC_W'(center), axis, DIM_W));

    // update_start takes precedence over any swap request in the same cycle.
    assign swap_en   = pt_ready && (ttl != '0) && !update_start;
    assign do_parent = swap_en && parent_swap;
    assign do_child  = swap_en && !parent_swap && child_swap;

    // Each dimension gets phase 0 (divider load) then ACC_W iteration cycles.
    assign div_start = (state == DIV) && (phase == '0);

    seq_divider #(
        .DVD_W (ACC_W),
        .DVS_W (CNT_W),
        .Q_W   (DIM_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (acc[dim_idx]),
        .divisor  (count),
        .quotient (div_quot),
        .done     (div_done)
    );

    // A quotient lands in the cycle after its last iteration: the next
    // dimension's load cycle, or DONE for the final dimension. Merging it
    // here lets DONE see the complete new centre.
    always_comb begin
        nc_merged = new_center;
        if (div_done) begin
            nc_merged[cap_idx*DIM_W +: DIM_W] = div_quot;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (update_start) state_next = (count_next == '0) ? DONE : DIV;
            DIV:  if (phase == PH_W'(ACC_W) && dim_idx == IDX_W'(DIM - 1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            center          <= INIT_CENTER;
            new_center      <= '0;
            parent_out      <= '0;
            child_out       <= '0;
            point_out       <= '0;
            point_out_valid <= 1'b0;
            go_left         <= 1'b0;
            update_done     <= 1'b0;
            stable          <= 1'b0;
            overflow        <= 1'b0;
            count           <= '0;
            ttl             <= '0;
            dim_idx         <= '0;
            cap_idx         <= '0;
            phase           <= '0;
            for (int d = 0; d < DIM; d++) acc[d] <= '0;
        end else begin
            point_out_valid <= accept;
            update_done     <= 1'b0;

            if (accept) begin
                point_out <= pt_data;
                go_left   <= (axis_pt < axis_ctr);
            end
            if (add_pt) begin
                for (int d = 0; d < DIM; d++) begin
                    acc[d] <= acc[d] + ACC_W'(pt_data[d*DIM_W +: DIM_W]);
                end
                count <= count_next;
            end
            if (accept && pt_assign && count_full) overflow <= 1'b1;

            if (sort_load)                      ttl <= depth;
            else if (next_level && ttl != '0)   ttl <= ttl - 1'b1;

            if (do_parent) begin
                parent_out <= center;
                center     <= parent_in;
                stable     <= 1'b0;
            end else if (do_child) begin
                child_out <= center;
                center    <= child_in;
                stable    <= 1'b0;
            end

            if (state == DIV) begin
                if (phase == PH_W'(ACC_W)) begin
                    phase   <= '0;
                    dim_idx <= dim_idx + 1'b1;
                end else begin
                    phase <= phase + 1'b1;
                end
            end else begin
                phase   <= '0;
                dim_idx <= '0;
            end
            if (div_start) cap_idx <= dim_idx;
            if (div_done)  new_center <= nc_merged;

            if (state == DONE) begin
                update_done <= 1'b1;
                if (count != '0) begin
                    stable <= (nc_merged == center);
                    center <= nc_merged;
                end else begin
                    stable <= 1'b1;
                end
                count <= '0;
                for (int d = 0; d < DIM; d++) acc[d] <= '0;
            end
        end
    end

endmodule

// File: doc/kmeans_cluster_pe.md
# kmeans_cluster_pe

Parametrised k-means cluster processing element and next-generation tree node for the kd-tree clustering datapath. It holds one cluster centre of `DIM` dimensions and accumulates the points assigned to it with true running sums and a point count. On request it recomputes the centre as the truncated mean, using an internal sequential divider, and reports stability. Between iterations it takes part in level-by-level centre sorting with its parent and child nodes, gated by a time-to-live counter.

## Interface
- `DIM`, 3: number of dimensions, ≥1.
- `DIM_W`, 8: bits per coordinate.
- `MAX_N`, 1000: maximum points per cluster per iteration.
- `MAX_DEPTH`, 16: maximum tree depth.
- `INIT_CENTER`, 0: centre reset value, `DIM*DIM_W` bits.
- Derived widths:
  - `CNT_W` = clog2(MAX_N+1).
  - `ACC_W` = DIM_W+CNT_W.
  - `DEP_W` = clog2(MAX_DEPTH).
  - `C_W` = DIM*DIM_W.
- Ports:
  - `clk` in 1: clock.
  - `rst` in 1: reset, synchronous, active-high.
  - `depth` in DEP_W: node depth in the tree.
  - `pt_valid` in 1, `pt_ready` out 1, `pt_data` in C_W, `pt_assign` in 1: point stream. `pt_assign`=1 adds the point to this cluster.
  - `point_out` out C_W, `point_out_valid` out 1, `go_left` out 1: point forwarded to the child level.
  - `sort_load` in 1, `next_level` in 1: time-to-live control.
  - `parent_swap` in 1, `child_swap` in 1: swap requests.
  - `parent_in` in C_W, `child_in` in C_W, `parent_out` out C_W, `child_out` out C_W: centre exchange with parent and child.
  - `update_start` in 1, `update_done` out 1: centre recompute request and completion pulse.
  - `center` out C_W, `count` out CNT_W, `stable` out 1, `overflow` out 1: status.

## Operation
- FSM states: IDLE, DIV, DONE.
  - `pt_ready`=1 only in IDLE.
  - Swaps are accepted only in IDLE.
- Point accept (`pt_valid`&&`pt_ready`):
  - `point_out`<=`pt_data` and `point_out_valid`<=1 for one cycle.
  - `go_left`<=(`pt_data` coordinate at axis `depth`%DIM) < (same coordinate of the current `center`). The comparison is unsigned.
  - If `pt_assign`=1 and `count`<MAX_N: acc[d]+=coord[d] for every d, and `count`+=1.
  - If `pt_assign`=1 and `count`==MAX_N: the point is dropped from the sums and `overflow` is set (sticky until `rst`). The point is still forwarded.
- Update sequence:
  - `update_start` in IDLE moves the FSM to DIV.
  - DIV processes one dimension at a time with a restoring divider: 1 load cycle plus ACC_W iterations per dimension.
  - Each result is floor(acc[d]/count), truncated to DIM_W bits into `new_center`.
  - DONE (one cycle):
    - `stable`<=(new_center==center).
    - `center`<=new_center.
    - accumulators, `count` <=0.
    - `update_done`=1.
    - FSM returns to IDLE.
  - `count`==0 at `update_start`: the FSM skips DIV and goes to DONE. `center` is unchanged and `stable`<=1.
- Time-to-live (`ttl`, DEP_W bits):
  - `sort_load` sets `ttl`<=`depth`.
  - `next_level` decrements `ttl`, saturating at 0.
  - Swaps are enabled only when `ttl`!=0.
- Swaps (IDLE, `ttl`!=0):
  - `parent_swap` does `parent_out`<=`center`, `center`<=`parent_in`.
  - Otherwise, `child_swap` does `child_out`<=`center`, `center`<=`child_in`.
  - `parent_swap` has priority over `child_swap`.
  - Any accepted swap clears `stable`.
  - Swaps never touch the accumulators or `count`.
- Simultaneous events:
  - `update_start` with a point accept: the point is accumulated and is included in the division.
  - `update_start` with a swap: the update proceeds and the swap is ignored.
  - Swap with a point accept: both occur, and `go_left` uses the pre-swap `center`.
  - `sort_load` with `next_level`: `sort_load` wins.
- Reset mid-operation: `rst` aborts DIV and restores all reset values next cycle.

## Timing
- Reset values:
  - `center`=INIT_CENTER.
  - `parent_out`, `child_out`, `point_out`=0.
  - `point_out_valid`, `go_left`, `update_done`, `stable`, `overflow`=0.
  - `count`=0, `ttl`=0.
  - `pt_ready`=1.
- `point_out`, `point_out_valid`, `go_left` are registered: 1-cycle latency from accept.
- `update_done` asserts exactly DIM*(ACC_W+1)+1 cycles after the `update_start` edge. With `count`==0 it asserts 1 cycle after.
- `center` and `stable` are valid in the same cycle that `update_done`=1.
- Swap results are visible on `center`, `parent_out`, `child_out` 1 cycle after the request.

## Structure
- Package `kmeans_pkg` holds:
  - the width functions (`CNT_W`, `ACC_W`, `DEP_W`, `C_W`);
  - the FSM state enum;
  - a coordinate-slice helper function.
- Sub-module `seq_divider` (ACC_W/CNT_W restoring divider with start/done) is instantiated once and reused across dimensions.

## Test plan
- Reset, then idle:
  - `center`==INIT_CENTER, `pt_ready`=1, all other outputs 0.
  - `update_start` with `count`==0 gives `update_done` after 1 cycle and `stable`=1.
- Accumulate and update (DIM=3, DIM_W=8):
  - Accept points [10,20,30], [20,40,61], [31,0,1] with `pt_assign`=1, then `update_start`.
  - `center`=[20,20,30] and `update_done` fire exactly DIM*(ACC_W+1)+1 cycles later; `count` becomes 0.
  - Repeat with the same three points: `stable`=1.
- `go_left` routing:
  - `depth`=4, `center`=[50,60,70]. The axis is 1 (`depth`%DIM).
  - `pt_data`=[99,59,0] gives `go_left`=1; `pt_data`=[0,60,0] gives `go_left`=0.
- Swap gating:
  - `depth`=2, `sort_load`, then `parent_swap` with `parent_in`=[1,2,3]: `center`=[1,2,3], `parent_out`=old centre, `stable` cleared.
  - After 2 `next_level` pulses, `child_swap` is ignored.
  - `parent_swap` and `child_swap` together: only the parent swap occurs.
- Overflow with MAX_N=4:
  - Five assigned points: `count`=4, `overflow`=1.
  - The fifth point is still forwarded with `point_out_valid`=1.
- Reset mid-DIV: `rst` asserted 5 cycles after `update_start` → no `update_done`; `center`=INIT_CENTER, `count`=0.
